// File: rtl/dmem_share_arbiter_pkg.sv
// Shared definitions for the node data-memory arbiter.
//   owner_e  : which requester (if any) owns the dmem port this cycle
//   DMEM_AW  : dmem word-address width
//   DMEM_DW  : dmem data width
package dmem_share_arbiter_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 64;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_EXT  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_share_arbiter_rd_tag_pipe.sv
// Read-return tag pipe: tracks each issued dmem read for RD_LAT cycles so the
// returning mem_rdata can be steered to the requester that issued it.
//   CLK       in   clock
//   RESET     in   synchronous active-high; drops every tag in flight
//   in_vld    in   a read was issued this cycle
//   in_owner  in   requester that issued it
//   out_vld   out  a read issued RD_LAT cycles ago returns now
//   out_owner out  requester that issued the returning read
module dmem_share_arbiter_rd_tag_pipe
  import dmem_share_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   CLK,
  input  logic   RESET,
  input  logic   in_vld,
  input  owner_e in_owner,
  output logic   out_vld,
  output owner_e out_owner
);

  logic   vld_p [RD_LAT];
  owner_e own_p [RD_LAT];

  // Stage 0 .. RD_LAT-1: one entry per cycle of dmem read latency
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= in_vld;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Owner tag is only meaningful alongside vld_p, so it needs no reset.
  always_ff @(posedge CLK) begin
    own_p[0] <= in_owner;
    for (int i = 1; i < RD_LAT; i++) own_p[i] <= own_p[i-1];
  end

  assign out_vld   = vld_p[RD_LAT-1];
  assign out_owner = own_p[RD_LAT-1];

endmodule

// File: rtl/dmem_share_arbiter.sv
// Shares one single-ported 256x64 dmem between the local CPU and the NIC
// remote-access (EXT) path. At most one access is issued per cycle; CPU wins
// by default, but EXT is forced through after STARVE_MAX consecutive denials.
// Read data is steered back to the issuing port RD_LAT cycles later.
//   CLK, RESET                      clock, synchronous active-high reset
//   cpu_req/wr/addr/wdata           CPU request (held by CPU while stalled)
//   cpu_stall, cpu_rvalid, cpu_rdata CPU handshake and read return
//   ext_req/wr/addr/wdata           EXT request (held until ext_gnt)
//   ext_gnt, ext_rvalid, ext_rdata  EXT handshake and read return
//   mem_en/wr_en/addr/wdata/rdata   dmem port
//   conflict_cnt                    saturating count of cycles both requested
module dmem_share_arbiter
  import dmem_share_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int RD_LAT     = 1,
  parameter int CNT_W      = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               cpu_req,
  input  logic               cpu_wr,
  input  logic [DMEM_AW-1:0] cpu_addr,
  input  logic [DMEM_DW-1:0] cpu_wdata,
  output logic               cpu_stall,
  output logic               cpu_rvalid,
  output logic [DMEM_DW-1:0] cpu_rdata,
  input  logic               ext_req,
  input  logic               ext_wr,
  input  logic [DMEM_AW-1:0] ext_addr,
  input  logic [DMEM_DW-1:0] ext_wdata,
  output logic               ext_gnt,
  output logic               ext_rvalid,
  output logic [DMEM_DW-1:0] ext_rdata,
  output logic               mem_en,
  output logic               mem_wr_en,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [DMEM_DW-1:0] mem_wdata,
  input  logic [DMEM_DW-1:0] mem_rdata,
  output logic [CNT_W-1:0]   conflict_cnt
);

  localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [3:0] starve_cnt;
  owner_e     owner;
  logic       tail_vld;
  owner_e     tail_owner;

  // Grant: EXT only wins a contested cycle once it has waited STARVE_MAX cycles.
  always_comb begin
    owner = OWNER_NONE;
    if (RESET) begin
      owner = OWNER_NONE;
    end else if (ext_req && (!cpu_req || starve_cnt == STARVE_LIM)) begin
      owner = OWNER_EXT;
    end else if (cpu_req) begin
      owner = OWNER_CPU;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (owner)
      OWNER_CPU: begin
        mem_en    = 1'b1;
        mem_wr_en = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWNER_EXT: begin
        mem_en    = 1'b1;
        mem_wr_en = ext_wr;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req && !RESET && (owner != OWNER_CPU);
  assign ext_gnt   = (owner == OWNER_EXT);

  always_ff @(posedge CLK) begin
    if (RESET || !ext_req || ext_gnt) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      conflict_cnt <= '0;
    end else if (cpu_req && ext_req) begin
      conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  dmem_share_arbiter_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_vld    (mem_en && !mem_wr_en),
    .in_owner  (owner),
    .out_vld   (tail_vld),
    .out_owner (tail_owner)
  );

  // Pipe tail: the stage registers still hold stale tags during the reset
  // cycle itself, so the returns are masked until the clear takes effect.
  assign cpu_rvalid = !RESET && tail_vld && (tail_owner == OWNER_CPU);
  assign ext_rvalid = !RESET && tail_vld && (tail_owner == OWNER_EXT);
  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_share_arbiter.sv
// Bench for dmem_share_arbiter: two instances (default parameters, and
// STARVE_MAX=1 / RD_LAT=2 / CNT_W=4), each attached to its own dmem model and
// scored against a cycle-level transaction model of the arbitration rules.
module tb_dmem_share_arbiter;

  localparam int SMAX0 = 4, LAT0 = 1;
  localparam int SMAX1 = 1, LAT1 = 2, CW1 = 4;

  logic CLK;
  logic RESET;
  logic preload;

  logic [1:0]  cpu_req, cpu_wr, ext_req, ext_wr;
  logic [7:0]  cpu_addr [2];
  logic [7:0]  ext_addr [2];
  logic [63:0] cpu_wdata [2];
  logic [63:0] ext_wdata [2];
  logic [1:0]  cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_en, mem_wr_en;
  logic [63:0] cpu_rdata [2];
  logic [63:0] ext_rdata [2];
  logic [63:0] mem_wdata [2];
  logic [63:0] mem_rdata [2];
  logic [7:0]  mem_addr  [2];
  logic [15:0] cc0;
  logic [3:0]  cc1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  dmem_share_arbiter u_dut0 (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(cpu_req[0]), .cpu_wr(cpu_wr[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_stall(cpu_stall[0]), .cpu_rvalid(cpu_rvalid[0]), .cpu_rdata(cpu_rdata[0]),
    .ext_req(ext_req[0]), .ext_wr(ext_wr[0]), .ext_addr(ext_addr[0]), .ext_wdata(ext_wdata[0]),
    .ext_gnt(ext_gnt[0]), .ext_rvalid(ext_rvalid[0]), .ext_rdata(ext_rdata[0]),
    .mem_en(mem_en[0]), .mem_wr_en(mem_wr_en[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .conflict_cnt(cc0)
  );

  dmem_share_arbiter #(.STARVE_MAX(SMAX1), .RD_LAT(LAT1), .CNT_W(CW1)) u_dut1 (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(cpu_req[1]), .cpu_wr(cpu_wr[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_stall(cpu_stall[1]), .cpu_rvalid(cpu_rvalid[1]), .cpu_rdata(cpu_rdata[1]),
    .ext_req(ext_req[1]), .ext_wr(ext_wr[1]), .ext_addr(ext_addr[1]), .ext_wdata(ext_wdata[1]),
    .ext_gnt(ext_gnt[1]), .ext_rvalid(ext_rvalid[1]), .ext_rdata(ext_rdata[1]),
    .mem_en(mem_en[1]), .mem_wr_en(mem_wr_en[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .conflict_cnt(cc1)
  );

  function automatic logic [63:0] init_val(input int i);
    return {32'hDEAD_BEEF, 24'h0, 8'(i)};
  endfunction

  // dmem models: single port, read data appears LAT cycles after mem_en
  logic [63:0] mem [2][256];
  logic [63:0] rdq [2][2];
  always @(posedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (preload) begin
        for (int i = 0; i < 256; i++) mem[d][i] <= init_val(i);
      end else if (mem_en[d] && mem_wr_en[d]) begin
        mem[d][mem_addr[d]] <= mem_wdata[d];
      end
      rdq[d][1] <= rdq[d][0];
      if (mem_en[d] && !mem_wr_en[d]) rdq[d][0] <= mem[d][mem_addr[d]];
    end
  end
  assign mem_rdata[0] = rdq[0][0];
  assign mem_rdata[1] = rdq[1][1];

  // Reference model state
  int          n_checks, n_errors;
  int          cyc;
  int          waited [2];
  int          confl  [2];
  logic [63:0] shadow [2][256];
  bit          ret_v   [2][8];
  bit          ret_ext [2][8];
  logic [63:0] ret_dat [2][8];
  bit          egnt_last [2];
  int          obs_gnt [2];
  int          obs_stall [2];
  int          obs_rv [2];

  function automatic int smax(input int d); return d == 0 ? SMAX0 : SMAX1; endfunction
  function automatic int lat(input int d);  return d == 0 ? LAT0 : LAT1;   endfunction
  function automatic int cmax(input int d); return d == 0 ? 65535 : (1 << CW1) - 1; endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_cycle(input int d);
    int          own;
    int          slot;
    bit          wr;
    logic [7:0]  a;
    logic [63:0] w;
    string       p;
    p    = $sformatf("d%0d c%0d ", d, cyc);
    slot = cyc % 8;
    check_eq({p, "conflict_cnt"}, (d == 0) ? 64'(cc0) : 64'(cc1), 64'(confl[d]));
    if (ext_gnt[d]) obs_gnt[d]++;
    if (cpu_stall[d]) obs_stall[d]++;
    if (cpu_rvalid[d] || ext_rvalid[d]) obs_rv[d]++;
    if (RESET) begin
      check_eq({p, "rst mem_en"},    64'(mem_en[d]), 0);
      check_eq({p, "rst mem_wr_en"}, 64'(mem_wr_en[d]), 0);
      check_eq({p, "rst ext_gnt"},   64'(ext_gnt[d]), 0);
      check_eq({p, "rst cpu_stall"}, 64'(cpu_stall[d]), 0);
      check_eq({p, "rst rvalids"},   64'({cpu_rvalid[d], ext_rvalid[d]}), 0);
      check_eq({p, "rst mem_addr"},  64'(mem_addr[d]), 0);
      check_eq({p, "rst mem_wdata"}, mem_wdata[d], 0);
      waited[d] = 0;
      confl[d]  = 0;
      egnt_last[d] = 1'b0;
      for (int i = 0; i < 8; i++) ret_v[d][i] = 1'b0;
      return;
    end
    own = 0;
    if (ext_req[d] && (!cpu_req[d] || waited[d] == smax(d))) own = 2;
    else if (cpu_req[d]) own = 1;
    check_eq({p, "mem_en"},    64'(mem_en[d]), 64'(own != 0));
    check_eq({p, "ext_gnt"},   64'(ext_gnt[d]), 64'(own == 2));
    check_eq({p, "cpu_stall"}, 64'(cpu_stall[d]), 64'(cpu_req[d] && own != 1));
    wr = (own == 2) ? ext_wr[d] : cpu_wr[d];
    a  = (own == 2) ? ext_addr[d] : cpu_addr[d];
    w  = (own == 2) ? ext_wdata[d] : cpu_wdata[d];
    if (own != 0) begin
      check_eq({p, "mem_wr_en"}, 64'(mem_wr_en[d]), 64'(wr));
      check_eq({p, "mem_addr"},  64'(mem_addr[d]), 64'(a));
      if (wr) check_eq({p, "mem_wdata"}, mem_wdata[d], w);
    end
    check_eq({p, "cpu_rvalid"}, 64'(cpu_rvalid[d]), 64'(ret_v[d][slot] && !ret_ext[d][slot]));
    check_eq({p, "ext_rvalid"}, 64'(ext_rvalid[d]), 64'(ret_v[d][slot] && ret_ext[d][slot]));
    if (ret_v[d][slot]) begin
      check_eq({p, "rdata"}, ret_ext[d][slot] ? ext_rdata[d] : cpu_rdata[d], ret_dat[d][slot]);
    end
    ret_v[d][slot] = 1'b0;
    if (own != 0) begin
      if (wr) begin
        shadow[d][a] = w;
      end else begin
        ret_v[d][(cyc + lat(d)) % 8]   = 1'b1;
        ret_ext[d][(cyc + lat(d)) % 8] = (own == 2);
        ret_dat[d][(cyc + lat(d)) % 8] = shadow[d][a];
      end
    end
    egnt_last[d] = (own == 2);
    if (!ext_req[d] || own == 2) waited[d] = 0;
    else waited[d]++;
    if (cpu_req[d] && ext_req[d] && confl[d] < cmax(d)) confl[d]++;
  endtask

  task automatic step();
    @(negedge CLK);
    for (int d = 0; d < 2; d++) model_cycle(d);
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cpu(input bit req, input bit wr, input logic [7:0] a, input logic [63:0] w);
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = req; cpu_wr[d] = wr; cpu_addr[d] = a; cpu_wdata[d] = w;
    end
  endtask

  task automatic set_ext(input bit req, input bit wr, input logic [7:0] a, input logic [63:0] w);
    for (int d = 0; d < 2; d++) begin
      ext_req[d] = req; ext_wr[d] = wr; ext_addr[d] = a; ext_wdata[d] = w;
    end
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 2; d++) begin
      obs_gnt[d] = 0; obs_stall[d] = 0; obs_rv[d] = 0;
    end
  endtask

  task automatic reset_cycle();
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      waited[d] = 0; confl[d] = 0; egnt_last[d] = 1'b0;
      for (int i = 0; i < 256; i++) shadow[d][i] = init_val(i);
      for (int i = 0; i < 8; i++) begin
        ret_v[d][i] = 1'b0; ret_ext[d][i] = 1'b0; ret_dat[d][i] = '0;
      end
    end
    clear_obs();
    preload = 1'b1;
    RESET   = 1'b1;
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    preload = 1'b0;
    reset_cycle();

    // CPU read alone of the preloaded word 0x05
    set_cpu(1, 0, 8'h05, 0);
    step();
    set_cpu(0, 0, 0, 0);
    repeat (3) step();

    // EXT write then CPU read of the same address
    set_ext(1, 1, 8'h10, 64'h1122_3344_5566_7788);
    step();
    set_ext(0, 0, 0, 0);
    set_cpu(1, 0, 8'h10, 0);
    step();
    set_cpu(0, 0, 0, 0);
    repeat (3) step();

    // Both requesting for 20 cycles
    reset_cycle();
    clear_obs();
    set_ext(1, 0, 8'h02, 0);
    for (int k = 0; k < 20; k++) begin
      set_cpu(1, 0, 8'($urandom_range(0, 31)), 0);
      step();
    end
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    check_eq("t3 d0 ext grants", 64'(obs_gnt[0]), 4);
    check_eq("t3 d0 cpu stalls", 64'(obs_stall[0]), 4);
    check_eq("t3 d1 ext grants", 64'(obs_gnt[1]), 10);
    check_eq("t3 d1 cpu stalls", 64'(obs_stall[1]), 10);
    step();
    check_eq("t3 d0 conflict_cnt", 64'(cc0), 20);
    check_eq("t3 d1 conflict_cnt sat", 64'(cc1), 15);
    repeat (3) step();

    // CPU read then EXT read on the next cycle, returns routed apart
    reset_cycle();
    set_cpu(1, 0, 8'h01, 0);
    step();
    set_cpu(0, 0, 0, 0);
    set_ext(1, 0, 8'h02, 0);
    step();
    set_ext(0, 0, 0, 0);
    repeat (4) step();

    // Reset while a read is in flight
    set_cpu(1, 0, 8'h03, 0);
    set_ext(1, 0, 8'h04, 0);
    step();
    set_ext(0, 0, 0, 0);
    set_cpu(1, 0, 8'h07, 0);
    step();
    reset_cycle();
    clear_obs();
    repeat (3) step();
    check_eq("t5 d0 no stale rvalid", 64'(obs_rv[0]), 0);
    check_eq("t5 d1 no stale rvalid", 64'(obs_rv[1]), 0);
    check_eq("t5 d0 conflict_cnt", 64'(cc0), 0);
    check_eq("t5 d1 conflict_cnt", 64'(cc1), 0);
    set_cpu(1, 0, 8'h09, 0);
    step();
    set_cpu(0, 0, 0, 0);
    repeat (3) step();

    // Randomized traffic; EXT holds its request until the model grants it
    for (int k = 0; k < 600; k++) begin
      RESET = ($urandom_range(0, 149) == 0);
      for (int d = 0; d < 2; d++) begin
        cpu_req[d]   = ($urandom_range(0, 3) != 0);
        cpu_wr[d]    = ($urandom_range(0, 2) == 0);
        cpu_addr[d]  = 8'($urandom_range(0, 15));
        cpu_wdata[d] = {$urandom, $urandom};
        if (!(ext_req[d] && !egnt_last[d])) begin
          ext_req[d]   = ($urandom_range(0, 2) != 0);
          ext_wr[d]    = ($urandom_range(0, 2) == 0);
          ext_addr[d]  = 8'($urandom_range(0, 15));
          ext_wdata[d] = {$urandom, $urandom};
        end
      end
      step();
    end
    RESET = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
